// File: rtl/rr_mux_pkg.sv
// Shared defaults and FSM encoding for the round-robin mux arbiter.
package rr_mux_pkg;
  localparam int N_REQ_DEF = 6;
  localparam int DW_DEF    = 4;
  localparam int SELW_DEF  = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rr_state_e;
endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping modulo N_REQ.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SELW-1:0]  last_grant,
  output logic             any_valid,
  output logic [SELW-1:0]  winner
);
  // Walk the scan backwards so the earliest position in scan order is written last.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % N_REQ;
      if (req[idx]) begin
        any_valid = 1'b1;
        winner    = SELW'(idx);
      end
    end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N_REQ:1 data select, feeding a one-entry output register.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_ready
);
  rr_state_e                  state;
  logic [SELW-1:0]            last_grant;
  logic                       any_valid;
  logic [SELW-1:0]            winner;
  logic                       can_load;
  logic                       capture;
  logic [N_REQ-1:0][DW-1:0]   data_arr;
  logic [DW-1:0]              sel_data;

  assign data_arr = req_data;

  rr_pick #(.N_REQ(N_REQ), .SELW(SELW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  assign can_load = (state == ST_EMPTY) || out_ready;
  assign capture  = can_load && any_valid && !reset;

  always_comb begin
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == SELW'(i)) begin
        sel_data     = data_arr[i];
        req_ready[i] = capture;
      end
    end
  end

  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SELW'(N_REQ - 1);
    end else begin
      case (state)
        ST_EMPTY: begin
          if (any_valid) begin
            state      <= ST_FULL;
            out_data   <= sel_data;
            out_sel    <= winner;
            last_grant <= winner;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (any_valid) begin
              out_data   <= sel_data;
              out_sel    <= winner;
              last_grant <= winner;
            end else begin
              // Drained with nothing to refill: idle output returns to the mux default.
              state    <= ST_EMPTY;
              out_data <= '0;
              out_sel  <= '0;
            end
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;
  localparam int N = 6;
  localparam int W = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  rr_mux_arbiter #(.N_REQ(N), .DW(W), .SELW(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic [S-1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic set_word(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  initial begin
    logic [S-1:0] exp_seq [8];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    #12;
    chk_out("reset", 1'b0, 4'h0, 3'd0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    reset = 1'b0;

    // single request from req 0
    set_word(0, 4'hA); req_valid = 6'b000001; out_ready = 1'b1;
    #1 chk("t1.ready", 32'(req_ready), 32'h01);
    tick; req_valid = '0;
    chk_out("t1.cap", 1'b1, 4'hA, 3'd0);
    tick;
    chk_out("t1.drain", 1'b0, 4'h0, 3'd0);

    // fairness: all six valid after a fresh reset
    reset = 1'b1; #2 reset = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, W'(i + 1));
    req_valid = '1; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2.ready%0d", k), 32'(req_ready), 32'(6'b1 << exp_seq[k]));
      tick;
      chk_out($sformatf("t2.out%0d", k), 1'b1, W'(exp_seq[k] + 1), exp_seq[k]);
    end
    req_valid = '0;
    tick;
    chk_out("t2.idle", 1'b0, 4'h0, 3'd0);

    // backpressure hold (last_grant=1, so req 2 wins alone)
    set_word(2, 4'h7); req_valid = 6'b000100;
    #1 chk("t3.ready2", 32'(req_ready), 32'h04);
    tick;
    set_word(4, 4'h9); req_valid = 6'b010000; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t3.stall_ready%0d", k), 32'(req_ready), 32'h0);
      tick;
      chk_out($sformatf("t3.hold%0d", k), 1'b1, 4'h7, 3'd2);
    end
    out_ready = 1'b1;
    #1 chk("t3.ready4", 32'(req_ready), 32'h10);
    tick; req_valid = '0;
    chk_out("t3.cap4", 1'b1, 4'h9, 3'd4);
    tick;

    // wrap: get last_grant=5, then req0 vs req5
    set_word(5, 4'h3); req_valid = 6'b100000;
    tick;
    chk_out("t4.cap5", 1'b1, 4'h3, 3'd5);
    set_word(0, 4'h1); req_valid = 6'b100001;
    #1 chk("t4.wrap_ready", 32'(req_ready), 32'h01);
    tick;
    chk_out("t4.wrap", 1'b1, 4'h1, 3'd0);
    #1 chk("t4.next_ready", 32'(req_ready), 32'h20);
    tick; req_valid = '0;
    chk_out("t4.next", 1'b1, 4'h3, 3'd5);
    tick;

    // async reset while FULL with out_sel=3
    set_word(3, 4'hC); req_valid = 6'b001000;
    tick;
    chk_out("t5.full", 1'b1, 4'hC, 3'd3);
    req_valid = 6'b001001;
    #2 reset = 1'b1;
    #1 chk_out("t5.async", 1'b0, 4'h0, 3'd0);
    chk("t5.rst_ready", 32'(req_ready), 32'h0);
    reset = 1'b0;
    #1 chk("t5.post_ready", 32'(req_ready), 32'h01);
    tick; req_valid = '0;
    chk_out("t5.post", 1'b1, 4'h1, 3'd0);
    tick;

    // idle cycles must not rotate priority (last_grant stays 0)
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("t6.idle%0d", k), 1'b0, 4'h0, 3'd0);
      chk($sformatf("t6.idle_ready%0d", k), 32'(req_ready), 32'h0);
      tick;
    end
    set_word(1, 4'h5); set_word(0, 4'hE); req_valid = 6'b000011;
    #1 chk("t6.ready1", 32'(req_ready), 32'h02);
    tick; req_valid = '0;
    chk_out("t6.cap1", 1'b1, 4'h5, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and output register that shares one 6:1, 4-bit select datapath among six requesters.
- Each requester presents a data word with a valid/ready handshake.
- The block chooses one requester, drives the select index, and captures the selected word into a one-entry output register.
- The output register is drained by a downstream valid/ready consumer.

Parameters:
- N_REQ, 6, number of requesters (legal range 2..8).
- DW, 4, data width per requester.
- SELW, 3, select/index width; must satisfy 2**SELW >= N_REQ.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_valid  input  N_REQ  per-requester valid; bit i belongs to requester i.
- req_data  input  N_REQ*DW  packed words; requester i occupies bits [i*DW +: DW].
- req_ready  output  N_REQ  one-hot or zero; bit i high means requester i's word is captured this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DW  captured word.
- out_sel  output  SELW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, last_grant=N_REQ-1. After reset, priority starts at requester 0.
- State: two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1). last_grant is an index register.
- can_load = EMPTY || (FULL && out_ready). This allows back-to-back transfers with no bubble.
- Pick: scan requesters with req_valid=1 in order last_grant+1, last_grant+2, ..., wrapping modulo N_REQ. The first one found is the winner g.
- Pick wrap-around: the index after N_REQ-1 is 0. The modulo is explicit for non-power-of-two N_REQ; the scan never indexes >= N_REQ.
- req_ready (combinational): req_ready[g]=1 only when can_load and any req_valid. All other bits are 0. No combinational path from req_ready back into the pick.
- On a clock edge with a capture:
  - out_data <= req_data[g]
  - out_sel <= g
  - last_grant <= g
  - state -> FULL
- Latency: requester handshake cycle N produces out_valid=1 with the data in cycle N+1.
- FULL && !out_ready: hold out_data and out_sel. req_ready is all zero. last_grant is unchanged.
- FULL && out_ready && no req_valid: state -> EMPTY, out_data <= 0, out_sel <= 0. Idle output matches the mux default of 0.
- EMPTY && no req_valid: remain EMPTY. Outputs stay 0.
- Simultaneous drain and new capture: both happen in the same cycle; out_valid stays 1 with the new word.
- last_grant changes only on capture. Idle cycles do not rotate priority.
- Requester protocol: a requester holds valid and data stable until it sees ready. A requester that drops valid before ready is simply not considered; this is not an error.
- Fairness: with all N_REQ requesters continuously valid and out_ready=1, grants cycle 0,1,...,N_REQ-1,0,... Any continuously valid requester waits at most N_REQ-1 captures.
- Reset mid-transfer: the in-flight output word is discarded, out_valid drops in the same cycle (async), and the pointer returns to N_REQ-1. No req_ready is asserted while reset is high.

Decomposition:
- Shared package rr_mux_pkg holds:
  - N_REQ_DEF, DW_DEF, SELW_DEF defaults.
  - FSM encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- One natural sub-module, rr_pick:
  - Combinational.
  - Inputs: req vector and last_grant.
  - Outputs: any_valid and winner index.
  - Verified standalone over all 2**N_REQ request patterns times N_REQ pointers.
- Top level holds the FSM, the output register, and the data select indexed by the winner.

Test Plan:
- Reset, then req_valid=6'b000001 with data0=4'hA and out_ready=1 -> req_ready=6'b000001 that cycle. Next cycle: out_valid=1, out_data=A, out_sel=0. Following cycle: out_valid=0, out_data=0.
- All six valid with data_i=i+1 and out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,4,5,0,1 with out_data 1..6,1,2, and no bubble cycles.
- Word captured from req 2 (data 4'h7), then out_ready=0 for 3 cycles while req 4 is valid -> out_data holds 7, req_ready stays 0. When out_ready=1, req 4 is captured in the same cycle, and the next cycle shows out_sel=4.
- last_grant=5 with req 0 and req 5 valid -> req 0 wins (wrap). Then with last_grant=0 and req 0 and req 5 valid -> req 5 wins.
- Assert reset asynchronously mid-cycle while FULL with out_sel=3 -> out_valid, out_data and out_sel go to 0 immediately. After release, req 3 and req 0 both valid -> req 0 wins.
- out_ready=1 with no requests for 5 cycles, then req 1 valid -> outputs stay 0 while idle, the capture goes to req 1, and last_grant was unchanged through the idle cycles.
